lcd_refresh_scheduler: RTL

Owns the LCD1602 bus for the medicine-kit display and replaces free-running per-edge command cycling with a timed sequencer. After reset it runs the HD44780 power-up and init sequence with proper enable-pulse and execution delays. It then refreshes both rows continuously from a 32-entry character shadow buffer. The shadow buffer is shared between a host write port, a bulk-clear requester and the refresh reader under fixed-priority arbitration.

---
 rtl/lcd_refresh_scheduler_if.sv | 19 +
 rtl/lcd_refresh_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_scheduler_if.sv
// Host-side port bundle: single-entry shadow writes and the bulk-clear request.
interface lcd_refresh_scheduler_if;
  logic       wr_req;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       clr_req;
  logic       clr_ack;

  modport master (
    output wr_req, wr_addr, wr_data, clr_req,
    input  wr_ack, clr_ack
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, clr_req,
    output wr_ack, clr_ack
  );
endinterface

// File: rtl/lcd_refresh_scheduler.sv
// HD44780 power-up/init sequencer followed by a continuous two-row refresh
// from a 32-byte shadow buffer that the host and a bulk clear can update.
module lcd_refresh_scheduler #(
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 20,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLR_WAIT_CYC   = 82000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  lcd_refresh_scheduler_if.slave        host,
  output logic                          init_done_o,
  output logic                          frame_tick_o,
  output logic                          lcd_rs_o,
  output logic                          lcd_rw_o,
  output logic                          lcd_en_o,
  output logic [7:0]                    lcd_data_o
);
  localparam logic [19:0] SETUP_M1  = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_M1     = 20'(EN_HIGH_CYC - 1);
  localparam logic [19:0] CMD_W     = 20'(CMD_WAIT_CYC);
  localparam logic [19:0] CLR_W     = 20'(CLR_WAIT_CYC);
  localparam logic [19:0] PWRUP_M1  = 20'(PWRUP_WAIT_CYC - 1);
  localparam logic [5:0]  LAST_STEP = 6'd33;

  typedef enum logic [1:0] {TOP_PWRUP, TOP_INIT, TOP_REFRESH} top_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  logic [7:0]  shadow_q [32];
  logic        fill_active_q;
  logic [4:0]  fill_idx_q;
  logic        fill_on;

  top_t        top_q;
  phase_t      phase_q;
  logic [19:0] cnt_q;
  logic [5:0]  step_q;
  logic        rs_q;
  logic        en_q;
  logic [7:0]  data_q;
  logic        init_done_q;
  logic        frame_tick_q;

  logic [19:0] wait_len;
  logic        last_txn;
  logic [5:0]  next_step;
  logic [4:0]  sh_idx;
  logic [8:0]  frame_word;

  // A clear request takes the write port on the very cycle it is seen.
  assign fill_on      = fill_active_q | host.clr_req;
  assign host.clr_ack = rst_n & fill_on & (fill_idx_q == 5'd31);
  assign host.wr_ack  = rst_n & host.wr_req & ~fill_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
      fill_active_q <= 1'b0;
      fill_idx_q    <= 5'd0;
    end else if (fill_on) begin
      shadow_q[fill_idx_q] <= 8'h20;
      fill_active_q        <= (fill_idx_q != 5'd31);
      fill_idx_q           <= fill_idx_q + 5'd1;
    end else if (host.wr_req) begin
      shadow_q[host.wr_addr] <= host.wr_data;
    end
  end

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 9'h038;
      2'd1:    init_word = 9'h00C;
      2'd2:    init_word = 9'h001;
      default: init_word = 9'h006;
    endcase
  endfunction

  assign wait_len  = (!rs_q && data_q == 8'h01) ? CLR_W : CMD_W;
  assign last_txn  = (top_q == TOP_REFRESH) && (step_q == LAST_STEP);
  assign next_step = (step_q == LAST_STEP) ? 6'd0 : step_q + 6'd1;
  // Frame slots 1..16 map to row 0, slots 18..33 to row 1.
  assign sh_idx    = (next_step <= 6'd16) ? 5'(next_step - 6'd1) : 5'(next_step - 6'd2);

  always_comb begin
    frame_word = 9'h080;
    if (next_step == 6'd17) frame_word = 9'h0C0;
    else if (next_step != 6'd0) frame_word = {1'b1, shadow_q[sh_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q        <= TOP_PWRUP;
      phase_q      <= PH_SETUP;
      cnt_q        <= 20'd0;
      step_q       <= 6'd0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      if (top_q == TOP_PWRUP) begin
        if (cnt_q == PWRUP_M1) begin
          top_q           <= TOP_INIT;
          phase_q         <= PH_SETUP;
          step_q          <= 6'd0;
          cnt_q           <= 20'd0;
          {rs_q, data_q}  <= init_word(2'd0);
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end else begin
        case (phase_q)
          PH_SETUP: begin
            if (cnt_q == SETUP_M1) begin
              phase_q <= PH_PULSE;
              en_q    <= 1'b1;
              cnt_q   <= 20'd0;
            end else begin
              cnt_q <= cnt_q + 20'd1;
            end
          end
          PH_PULSE: begin
            if (cnt_q == EN_M1) begin
              phase_q      <= PH_WAIT;
              en_q         <= 1'b0;
              cnt_q        <= 20'd0;
              frame_tick_q <= last_txn && (wait_len == 20'd1);
            end else begin
              cnt_q <= cnt_q + 20'd1;
            end
          end
          default: begin
            if (cnt_q == wait_len - 20'd1) begin
              phase_q <= PH_SETUP;
              cnt_q   <= 20'd0;
              if (top_q == TOP_INIT && step_q == 6'd3) begin
                top_q          <= TOP_REFRESH;
                init_done_q    <= 1'b1;
                step_q         <= 6'd0;
                {rs_q, data_q} <= 9'h080;
              end else if (top_q == TOP_INIT) begin
                step_q         <= step_q + 6'd1;
                {rs_q, data_q} <= init_word(step_q[1:0] + 2'd1);
              end else begin
                step_q         <= next_step;
                {rs_q, data_q} <= frame_word;
              end
            end else begin
              cnt_q        <= cnt_q + 20'd1;
              // Registered, so raised one cycle ahead of the last WAIT cycle.
              frame_tick_q <= last_txn && (cnt_q + 20'd2 == wait_len);
            end
          end
        endcase
      end
    end
  end

  assign init_done_o  = init_done_q;
  assign frame_tick_o = frame_tick_q;
  assign lcd_rs_o     = rs_q;
  assign lcd_rw_o     = 1'b0;
  assign lcd_en_o     = en_q;
  assign lcd_data_o   = data_q;
endmodule
